// File: rtl/forward_scoreboard_if.sv
// Bundle between the ID/EX register, the forwarding scoreboard and the EX operand muxes.
interface forward_scoreboard_if #(
   parameter int unsigned REG_AW = 3,
   parameter int unsigned LANES  = 2,
   parameter int unsigned NSRC   = 3,
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned CNT_W  = 16
);
   localparam int unsigned SELW = $clog2(1 + DEPTH * LANES);

   logic [LANES-1:0]             issue_valid;
   logic [LANES-1:0]             issue_we;
   logic [LANES-1:0]             issue_load;
   logic [LANES*REG_AW-1:0]      issue_rd;
   logic [LANES-1:0]             issue_setflag;
   logic [LANES-1:0]             ex_flag_n;
   logic [LANES*NSRC*REG_AW-1:0] id_src;
   logic                         flush;
   logic [LANES*NSRC*SELW-1:0]   fwd_sel;
   logic                         stall;
   logic                         flag_n;
   logic [CNT_W-1:0]             stall_cnt;

   // Pipeline side: presents the ID/EX packet, consumes bypass controls
   modport master (
      output issue_valid, issue_we, issue_load, issue_rd, issue_setflag, ex_flag_n, id_src,
             flush,
      input  fwd_sel, stall, flag_n, stall_cnt
   );

   // Scoreboard side
   modport slave (
      input  issue_valid, issue_we, issue_load, issue_rd, issue_setflag, ex_flag_n, id_src,
             flush,
      output fwd_sel, stall, flag_n, stall_cnt
   );
endinterface

// File: rtl/forward_scoreboard.sv
// In-flight write scoreboard for the EX/MEM..MEM/WB window: bypass selects, load-use stall,
// N-flag forwarding and a saturating stall counter.
module forward_scoreboard #(
   parameter int unsigned REG_AW = 3,
   parameter int unsigned LANES  = 2,
   parameter int unsigned NSRC   = 3,
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned CNT_W  = 16
) (
   input logic                clk,
   input logic                rst_n,
   forward_scoreboard_if.slave bus
);
   localparam int unsigned SELW = $clog2(1 + DEPTH * LANES);

   // Index 0 is stage 1 (EX/MEM), index DEPTH-1 is MEM/WB
   logic [DEPTH-1:0][LANES-1:0]             valid_q, valid_d;
   logic [DEPTH-1:0][LANES-1:0]             we_q, we_d;
   logic [DEPTH-1:0][LANES-1:0]             load_q, load_d;
   logic [DEPTH-1:0][LANES-1:0]             setflag_q, setflag_d;
   logic [DEPTH-1:0][LANES-1:0]             n_q, n_d;
   logic [DEPTH-1:0][LANES-1:0][REG_AW-1:0] rd_q, rd_d;
   logic                                    arch_n_q, arch_n_d;
   logic [CNT_W-1:0]                        stall_cnt_q, stall_cnt_d;

   logic [LANES*NSRC*SELW-1:0] fwd_sel;
   logic                       stall;
   logic                       flag_n;
   logic [REG_AW-1:0]          src_x;
   logic                       found_x;
   logic                       ld_win;
   logic                       found_f;

   // Bypass select per source: first hit scanning oldest-stage-last, youngest-lane-first
   always_comb begin
      fwd_sel = '0;
      stall   = 1'b0;
      src_x   = '0;
      found_x = 1'b0;
      ld_win  = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         for (int s = 0; s < NSRC; s++) begin
            src_x   = bus.id_src[(l*NSRC+s)*REG_AW +: REG_AW];
            found_x = 1'b0;
            ld_win  = 1'b0;
            for (int d = 0; d < DEPTH; d++) begin
               for (int j = LANES - 1; j >= 0; j--) begin
                  if (!found_x && valid_q[d][j] && we_q[d][j] && (rd_q[d][j] == src_x) &&
                      (src_x != '0)) begin
                     found_x = 1'b1;
                     fwd_sel[(l*NSRC+s)*SELW +: SELW] = SELW'(1 + d*LANES + j);
                     // Load data is not ready until stage 2
                     ld_win = (d == 0) && load_q[d][j];
                  end
               end
            end
            if (bus.issue_valid[l] && ld_win) begin
               stall = 1'b1;
            end
         end
      end
   end

   // Youngest in-flight flag setter wins, otherwise the architectural flag
   always_comb begin
      flag_n  = arch_n_q;
      found_f = 1'b0;
      for (int d = 0; d < DEPTH; d++) begin
         for (int j = LANES - 1; j >= 0; j--) begin
            if (!found_f && valid_q[d][j] && setflag_q[d][j]) begin
               found_f = 1'b1;
               flag_n  = n_q[d][j];
            end
         end
      end
   end

   // Next state: flush kills entries; otherwise shift, load stage 1 or a bubble, retire
   always_comb begin
      valid_d     = valid_q;
      we_d        = we_q;
      load_d      = load_q;
      setflag_d   = setflag_q;
      n_d         = n_q;
      rd_d        = rd_q;
      arch_n_d    = arch_n_q;
      stall_cnt_d = stall_cnt_q;
      if (bus.flush) begin
         valid_d = '0;
      end else begin
         for (int d = DEPTH - 1; d > 0; d--) begin
            valid_d[d]   = valid_q[d-1];
            we_d[d]      = we_q[d-1];
            load_d[d]    = load_q[d-1];
            setflag_d[d] = setflag_q[d-1];
            n_d[d]       = n_q[d-1];
            rd_d[d]      = rd_q[d-1];
         end
         valid_d[0]   = stall ? '0 : bus.issue_valid;
         we_d[0]      = bus.issue_we;
         load_d[0]    = bus.issue_load;
         setflag_d[0] = bus.issue_setflag;
         n_d[0]       = bus.ex_flag_n;
         for (int l = 0; l < LANES; l++) begin
            rd_d[0][l] = bus.issue_rd[l*REG_AW +: REG_AW];
         end
         // Ascending scan so the highest retiring setter lands last
         for (int l = 0; l < LANES; l++) begin
            if (valid_q[DEPTH-1][l] && setflag_q[DEPTH-1][l]) begin
               arch_n_d = n_q[DEPTH-1][l];
            end
         end
         if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= '0;
         we_q        <= '0;
         load_q      <= '0;
         setflag_q   <= '0;
         n_q         <= '0;
         rd_q        <= '0;
         arch_n_q    <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         valid_q     <= valid_d;
         we_q        <= we_d;
         load_q      <= load_d;
         setflag_q   <= setflag_d;
         n_q         <= n_d;
         rd_q        <= rd_d;
         arch_n_q    <= arch_n_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.fwd_sel   = fwd_sel;
   assign bus.stall     = stall;
   assign bus.flag_n    = flag_n;
   assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed vector bench for forward_scoreboard at default parameters.
module tb_forward_scoreboard;
   localparam int unsigned REG_AW = 3;
   localparam int unsigned LANES  = 2;
   localparam int unsigned NSRC   = 3;
   localparam int unsigned DEPTH  = 2;
   localparam int unsigned CNT_W  = 16;

   typedef struct {
      string       nm;
      logic [1:0]  valid;
      logic [1:0]  we;
      logic [1:0]  load;
      logic [5:0]  rd;
      logic [1:0]  sf;
      logic [1:0]  exn;
      logic [17:0] src;
      logic        flush;
      logic [17:0] sel;
      logic        stall;
      logic        flag;
      logic [15:0] cnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   vec_t v[$];

   always #5 clk = ~clk;

   forward_scoreboard_if #(
      .REG_AW(REG_AW), .LANES(LANES), .NSRC(NSRC), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) bus ();

   forward_scoreboard #(
      .REG_AW(REG_AW), .LANES(LANES), .NSRC(NSRC), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // 3-bit field for source s of lane l (used for both id_src and fwd_sel packing)
   function automatic logic [17:0] sp(int l, int s, logic [2:0] val);
      logic [17:0] r;
      r = '0;
      r[(l*3+s)*3 +: 3] = val;
      return r;
   endfunction

   function automatic vec_t mk(string nm, logic [1:0] valid, logic [1:0] we, logic [1:0] load,
                               logic [5:0] rd, logic [1:0] sf, logic [1:0] exn,
                               logic [17:0] src, logic flush, logic [17:0] sel, logic stall,
                               logic flag, logic [15:0] cnt);
      vec_t t;
      t.nm = nm; t.valid = valid; t.we = we; t.load = load; t.rd = rd; t.sf = sf; t.exn = exn;
      t.src = src; t.flush = flush; t.sel = sel; t.stall = stall; t.flag = flag; t.cnt = cnt;
      return t;
   endfunction

   task automatic drive(vec_t t);
      bus.issue_valid   = t.valid;
      bus.issue_we      = t.we;
      bus.issue_load    = t.load;
      bus.issue_rd      = t.rd;
      bus.issue_setflag = t.sf;
      bus.ex_flag_n     = t.exn;
      bus.id_src        = t.src;
      bus.flush         = t.flush;
   endtask

   task automatic idle();
      drive(mk("idle", 2'b00, 2'b00, 2'b00, 6'd0, 2'b00, 2'b00, 18'd0, 1'b0, 18'd0, 1'b0,
               1'b0, 16'd0));
   endtask

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end
   endtask

   task automatic chk_all(string nm, logic [17:0] sel, logic stall, logic flag, logic [15:0] cnt);
      chk({nm, ".fwd_sel"}, 32'(bus.fwd_sel), 32'(sel));
      chk({nm, ".stall"}, 32'(bus.stall), 32'(stall));
      chk({nm, ".flag_n"}, 32'(bus.flag_n), 32'(flag));
      chk({nm, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(cnt));
   endtask

   initial begin
      //         name        valid  we     load   rd          sf     exn    src          fl
      //         sel          stall flag cnt
      v.push_back(mk("alu_prod", 2'b01, 2'b01, 2'b00, {3'd0, 3'd3}, 2'b00, 2'b00, 18'd0, 1'b0,
                     18'd0, 1'b0, 1'b0, 16'd0));
      v.push_back(mk("alu_s1", 2'b10, 2'b00, 2'b00, 6'd0, 2'b00, 2'b00, sp(1, 0, 3), 1'b0,
                     sp(1, 0, 1), 1'b0, 1'b0, 16'd0));
      v.push_back(mk("alu_s2", 2'b10, 2'b00, 2'b00, 6'd0, 2'b00, 2'b00, sp(1, 0, 3), 1'b0,
                     sp(1, 0, 3), 1'b0, 1'b0, 16'd0));
      v.push_back(mk("pkt_prod", 2'b11, 2'b11, 2'b00, {3'd5, 3'd5}, 2'b00, 2'b00, 18'd0, 1'b0,
                     18'd0, 1'b0, 1'b0, 16'd0));
      v.push_back(mk("pkt_cons", 2'b01, 2'b00, 2'b00, 6'd0, 2'b00, 2'b00, sp(0, 1, 5), 1'b0,
                     sp(0, 1, 2), 1'b0, 1'b0, 16'd0));
      v.push_back(mk("ld_prod", 2'b01, 2'b01, 2'b01, {3'd0, 3'd4}, 2'b00, 2'b00, 18'd0, 1'b0,
                     18'd0, 1'b0, 1'b0, 16'd0));
      v.push_back(mk("ld_stall", 2'b10, 2'b00, 2'b00, 6'd0, 2'b00, 2'b00, sp(1, 2, 4), 1'b0,
                     sp(1, 2, 1), 1'b1, 1'b0, 16'd0));
      v.push_back(mk("ld_fwd", 2'b10, 2'b00, 2'b00, 6'd0, 2'b00, 2'b00, sp(1, 2, 4), 1'b0,
                     sp(1, 2, 3), 1'b0, 1'b0, 16'd1));
      v.push_back(mk("zr_prod", 2'b01, 2'b01, 2'b00, {3'd0, 3'd0}, 2'b00, 2'b00, 18'd0, 1'b0,
                     18'd0, 1'b0, 1'b0, 16'd1));
      v.push_back(mk("zr_cons", 2'b01, 2'b00, 2'b00, 6'd0, 2'b00, 2'b00, sp(0, 0, 0), 1'b0,
                     18'd0, 1'b0, 1'b0, 16'd1));
      v.push_back(mk("fl_prod", 2'b01, 2'b01, 2'b00, {3'd0, 3'd2}, 2'b01, 2'b01, 18'd0, 1'b0,
                     18'd0, 1'b0, 1'b0, 16'd1));
      v.push_back(mk("fl_flush", 2'b01, 2'b00, 2'b00, 6'd0, 2'b00, 2'b00, sp(0, 0, 2), 1'b1,
                     sp(0, 0, 1), 1'b0, 1'b1, 16'd1));
      v.push_back(mk("fl_after", 2'b01, 2'b00, 2'b00, 6'd0, 2'b00, 2'b00, sp(0, 0, 2), 1'b0,
                     18'd0, 1'b0, 1'b0, 16'd1));
      v.push_back(mk("fs_prod", 2'b01, 2'b01, 2'b01, {3'd0, 3'd6}, 2'b00, 2'b00, 18'd0, 1'b0,
                     18'd0, 1'b0, 1'b0, 16'd1));
      v.push_back(mk("fs_flush", 2'b01, 2'b00, 2'b00, 6'd0, 2'b00, 2'b00, sp(0, 0, 6), 1'b1,
                     sp(0, 0, 1), 1'b1, 1'b0, 16'd1));
      v.push_back(mk("fs_after", 2'b01, 2'b00, 2'b00, 6'd0, 2'b00, 2'b00, sp(0, 0, 6), 1'b0,
                     18'd0, 1'b0, 1'b0, 16'd1));
      v.push_back(mk("fg_set", 2'b10, 2'b00, 2'b00, 6'd0, 2'b10, 2'b10, 18'd0, 1'b0,
                     18'd0, 1'b0, 1'b0, 16'd1));
      v.push_back(mk("fg_s1", 2'b00, 2'b00, 2'b00, 6'd0, 2'b00, 2'b00, 18'd0, 1'b0,
                     18'd0, 1'b0, 1'b1, 16'd1));
      v.push_back(mk("fg_s2", 2'b00, 2'b00, 2'b00, 6'd0, 2'b00, 2'b00, 18'd0, 1'b0,
                     18'd0, 1'b0, 1'b1, 16'd1));
      v.push_back(mk("fg_arch", 2'b00, 2'b00, 2'b00, 6'd0, 2'b00, 2'b00, 18'd0, 1'b0,
                     18'd0, 1'b0, 1'b1, 16'd1));
      v.push_back(mk("fy_set", 2'b11, 2'b00, 2'b00, 6'd0, 2'b11, 2'b01, 18'd0, 1'b0,
                     18'd0, 1'b0, 1'b1, 16'd1));
      v.push_back(mk("fy_s1", 2'b00, 2'b00, 2'b00, 6'd0, 2'b00, 2'b00, 18'd0, 1'b0,
                     18'd0, 1'b0, 1'b0, 16'd1));
      v.push_back(mk("fy_s2", 2'b00, 2'b00, 2'b00, 6'd0, 2'b00, 2'b00, 18'd0, 1'b0,
                     18'd0, 1'b0, 1'b0, 16'd1));
      v.push_back(mk("fy_arch", 2'b00, 2'b00, 2'b00, 6'd0, 2'b00, 2'b00, 18'd0, 1'b0,
                     18'd0, 1'b0, 1'b0, 16'd1));
      v.push_back(mk("iv_prod", 2'b01, 2'b01, 2'b01, {3'd0, 3'd7}, 2'b00, 2'b00, 18'd0, 1'b0,
                     18'd0, 1'b0, 1'b0, 16'd1));
      v.push_back(mk("iv_cons", 2'b00, 2'b00, 2'b00, 6'd0, 2'b00, 2'b00, sp(0, 0, 7), 1'b0,
                     sp(0, 0, 1), 1'b0, 1'b0, 16'd1));
      v.push_back(mk("pr_p0", 2'b01, 2'b01, 2'b00, {3'd0, 3'd1}, 2'b00, 2'b00, 18'd0, 1'b0,
                     18'd0, 1'b0, 1'b0, 16'd1));
      v.push_back(mk("pr_p1", 2'b10, 2'b10, 2'b00, {3'd1, 3'd0}, 2'b00, 2'b00, 18'd0, 1'b0,
                     18'd0, 1'b0, 1'b0, 16'd1));
      v.push_back(mk("pr_cons", 2'b01, 2'b00, 2'b00, 6'd0, 2'b00, 2'b00, sp(0, 0, 1), 1'b0,
                     sp(0, 0, 2), 1'b0, 1'b0, 16'd1));

      // Reset held with random inputs
      idle();
      repeat (3) begin
         @(negedge clk);
         bus.issue_valid   = 2'($urandom);
         bus.issue_we      = 2'($urandom);
         bus.issue_load    = 2'($urandom);
         bus.issue_rd      = 6'($urandom);
         bus.issue_setflag = 2'($urandom);
         bus.ex_flag_n     = 2'($urandom);
         bus.id_src        = 18'($urandom);
         bus.flush         = 1'($urandom);
         #1;
         chk_all("reset", 18'd0, 1'b0, 1'b0, 16'd0);
      end
      @(negedge clk);
      idle();
      rst_n = 1'b1;

      foreach (v[i]) begin
         @(negedge clk);
         drive(v[i]);
         #1;
         chk_all(v[i].nm, v[i].sel, v[i].stall, v[i].flag, v[i].cnt);
      end

      // Second load-use: counter reaches 2
      @(negedge clk);
      drive(mk("l2p", 2'b01, 2'b01, 2'b01, {3'd0, 3'd3}, 2'b00, 2'b00, 18'd0, 1'b0, 18'd0, 1'b0,
               1'b0, 16'd0));
      @(negedge clk);
      drive(mk("l2c", 2'b01, 2'b00, 2'b00, 6'd0, 2'b00, 2'b00, sp(0, 0, 3), 1'b0, 18'd0, 1'b0,
               1'b0, 16'd0));
      #1;
      chk_all("ld2_stall", sp(0, 0, 1), 1'b1, 1'b0, 16'd1);
      @(negedge clk);
      idle();
      #1;
      chk_all("ld2_cnt", 18'd0, 1'b0, 1'b0, 16'd2);

      // Asynchronous reset in the middle of a stall cycle
      @(negedge clk);
      drive(mk("l3p", 2'b01, 2'b01, 2'b01, {3'd0, 3'd3}, 2'b00, 2'b00, 18'd0, 1'b0, 18'd0, 1'b0,
               1'b0, 16'd0));
      @(negedge clk);
      drive(mk("l3c", 2'b01, 2'b00, 2'b00, 6'd0, 2'b00, 2'b00, sp(0, 0, 3), 1'b0, 18'd0, 1'b0,
               1'b0, 16'd0));
      #1;
      chk_all("ld3_stall", sp(0, 0, 1), 1'b1, 1'b0, 16'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 18'd0, 1'b0, 1'b0, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_all("post_rst", 18'd0, 1'b0, 1'b0, 16'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
